pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. Each cycle it combines a load-use hazard in ID/EX, a taken branch resolved in EX, and a data-memory wait. From these it drives the PC enable, the IF/ID stall/flush pair, the ID/EX bubble and the back-end freeze. It also runs a multi-cycle squash window after a redirect to cover instruction-memory latency, and keeps saturating performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch redirects,
// data-memory freezes, a post-redirect squash window, and saturating performance counters.
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             pc_redirect,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_freeze,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SQUASH = 2'd1
    } state_t;

    localparam logic [2:0]       SQ_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = 1;

    state_t     state_q, state_d;
    logic [2:0] sq_q, sq_d;
    logic       load_use;
    logic       stall_inc, flush_inc;

    assign load_use = id_valid && ex_is_load && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    assign ctrl_state = state_q;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        sq_d        = sq_q;
        pc_en       = 1'b0;
        pc_redirect = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        if (reset) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (mem_busy) begin
            // A branch seen while frozen is dropped here; EX holds it, so it returns on release.
            pipe_freeze = 1'b1;
            ifid_stall  = 1'b1;
            stall_inc   = 1'b1;
        end else if (ex_branch_taken) begin
            pc_en       = 1'b1;
            pc_redirect = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            flush_inc   = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = ST_SQUASH;
                sq_d    = SQ_RELOAD;
            end else begin
                state_d = ST_RUN;
                sq_d    = 3'd0;
            end
        end else if (state_q == ST_SQUASH) begin
            // ID is already invalid during the squash, so no bubble and load_use is moot.
            pc_en      = 1'b1;
            ifid_flush = 1'b1;
            if (sq_q <= 3'd1) begin
                state_d = ST_RUN;
                sq_d    = 3'd0;
            end else begin
                sq_d = sq_q - 3'd1;
            end
        end else if (load_use) begin
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
            stall_inc   = 1'b1;
        end else begin
            pc_en = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            sq_q      <= 3'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state_q <= state_d;
            sq_q    <= sq_d;
            if (stall_inc && (stall_cnt != CNT_MAX))
                stall_cnt <= stall_cnt + CNT_ONE;
            if (flush_inc && (flush_cnt != CNT_MAX))
                flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by random traffic,
// all checked against a cycle-level reference model that counts remaining squash slots.
module tb_pipe_hazard_ctrl;

    localparam int TB_FLUSH = 2;
    localparam int TB_CNT_W = 4;
    localparam int CNT_SAT  = (1 << TB_CNT_W) - 1;

    logic                clk = 1'b0;
    logic                reset;
    logic                id_valid;
    logic [4:0]          id_rs1, id_rs2;
    logic                id_uses_rs1, id_uses_rs2;
    logic                ex_is_load;
    logic [4:0]          ex_rd;
    logic                ex_branch_taken;
    logic                mem_busy;
    logic                pc_en, pc_redirect, ifid_stall, ifid_flush, idex_bubble, pipe_freeze;
    logic [1:0]          ctrl_state;
    logic [TB_CNT_W-1:0] stall_cnt, flush_cnt;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state: squash slots still owed after a redirect, and counter values.
    int squash_left;
    int stall_m;
    int flush_m;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(TB_FLUSH), .CNT_W(TB_CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_is_load      (ex_is_load),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .mem_busy        (mem_busy),
        .pc_en           (pc_en),
        .pc_redirect     (pc_redirect),
        .ifid_stall      (ifid_stall),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .pipe_freeze     (pipe_freeze),
        .ctrl_state      (ctrl_state),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        reset           = 1'b0;
        id_valid        = 1'b0;
        id_rs1          = 5'd0;
        id_rs2          = 5'd0;
        id_uses_rs1     = 1'b0;
        id_uses_rs2     = 1'b0;
        ex_is_load      = 1'b0;
        ex_rd           = 5'd0;
        ex_branch_taken = 1'b0;
        mem_busy        = 1'b0;
    endtask

    // Check all outputs mid-cycle against the model, then advance the model at the edge.
    task automatic cycle();
        bit lu;
        bit e_pc, e_red, e_stl, e_fl, e_bub, e_frz;
        @(negedge clk);
        lu = id_valid && ex_is_load && (ex_rd != 0) &&
             ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        {e_pc, e_red, e_stl, e_fl, e_bub, e_frz} = '0;
        if (reset) begin
            e_fl = 1; e_bub = 1;
        end else if (mem_busy) begin
            e_frz = 1; e_stl = 1;
        end else if (ex_branch_taken) begin
            e_pc = 1; e_red = 1; e_fl = 1; e_bub = 1;
        end else if (squash_left > 0) begin
            e_pc = 1; e_fl = 1;
        end else if (lu) begin
            e_stl = 1; e_bub = 1;
        end else begin
            e_pc = 1;
        end
        chk("pc_en",       32'(pc_en),       32'(e_pc));
        chk("pc_redirect", 32'(pc_redirect), 32'(e_red));
        chk("ifid_stall",  32'(ifid_stall),  32'(e_stl));
        chk("ifid_flush",  32'(ifid_flush),  32'(e_fl));
        chk("idex_bubble", 32'(idex_bubble), 32'(e_bub));
        chk("pipe_freeze", 32'(pipe_freeze), 32'(e_frz));
        chk("ctrl_state",  32'(ctrl_state),  (squash_left > 0) ? 32'd1 : 32'd0);
        chk("stall_cnt",   32'(stall_cnt),   32'(stall_m));
        chk("flush_cnt",   32'(flush_cnt),   32'(flush_m));
        @(posedge clk);
        if (reset) begin
            squash_left = 0; stall_m = 0; flush_m = 0;
        end else if (mem_busy) begin
            stall_m = (stall_m < CNT_SAT) ? stall_m + 1 : CNT_SAT;
        end else if (ex_branch_taken) begin
            flush_m     = (flush_m < CNT_SAT) ? flush_m + 1 : CNT_SAT;
            squash_left = TB_FLUSH - 1;
        end else if (squash_left > 0) begin
            squash_left = squash_left - 1;
        end else if (lu) begin
            stall_m = (stall_m < CNT_SAT) ? stall_m + 1 : CNT_SAT;
        end
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        id_valid    = 1'b1;
        id_rs1      = 5'd5;
        id_uses_rs1 = 1'b1;
        ex_is_load  = 1'b1;
        ex_rd       = rd;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        squash_left = 0; stall_m = 0; flush_m = 0;

        // Reset outputs, then one idle cycle in RUN.
        cycle();
        reset = 1'b0;
        cycle();

        // Load-use on rs1 stalls once; same pattern with ex_rd = 0 does not.
        set_load_use(5'd5);
        cycle();
        idle_inputs();
        cycle();
        chk("stall_cnt_after_lu", 32'(stall_cnt), 32'd1);
        set_load_use(5'd0);
        cycle();
        idle_inputs();
        // Load-use through rs2 only.
        id_valid = 1'b1; id_rs2 = 5'd9; id_uses_rs2 = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd9;
        cycle();
        idle_inputs();

        // Redirect: squash window, then back to RUN.
        do_reset();
        ex_branch_taken = 1'b1;
        cycle();
        ex_branch_taken = 1'b0;
        cycle();
        cycle();
        chk("flush_cnt_after_br", 32'(flush_cnt), 32'd1);

        // Branch coincident with load_use: redirect wins, no stall counted.
        do_reset();
        set_load_use(5'd5);
        ex_branch_taken = 1'b1;
        cycle();
        idle_inputs();
        set_load_use(5'd5);
        cycle();
        idle_inputs();
        cycle();

        // mem_busy for three cycles inside the squash window, with a masked branch.
        do_reset();
        ex_branch_taken = 1'b1;
        cycle();
        ex_branch_taken = 1'b0;
        mem_busy = 1'b1;
        cycle();
        ex_branch_taken = 1'b1;
        cycle();
        ex_branch_taken = 1'b0;
        cycle();
        mem_busy = 1'b0;
        cycle();
        cycle();
        // New branch during squash reloads the window.
        ex_branch_taken = 1'b1;
        cycle();
        cycle();
        ex_branch_taken = 1'b0;
        cycle();
        cycle();

        // Counter saturation: 20 consecutive load-use cycles.
        do_reset();
        set_load_use(5'd5);
        repeat (20) cycle();
        idle_inputs();
        cycle();
        chk("stall_cnt_sat", 32'(stall_cnt), 32'(CNT_SAT));

        // Reset in the middle of a squash aborts it.
        ex_branch_taken = 1'b1;
        cycle();
        ex_branch_taken = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();

        // Random traffic on a small register set to hit hazards often.
        for (int i = 0; i < 400; i++) begin
            reset           = ($urandom_range(0, 59) == 0);
            id_valid        = ($urandom_range(0, 3) != 0);
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            id_uses_rs1     = 1'($urandom_range(0, 1));
            id_uses_rs2     = 1'($urandom_range(0, 1));
            ex_is_load      = 1'($urandom_range(0, 1));
            ex_rd           = 5'($urandom_range(0, 3));
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            mem_busy        = ($urandom_range(0, 4) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
